serial_tx: RTL

SERIAL_TX -- requirements
Module: serial_tx

---
 rtl/serial_tx_if.sv | 18 +
 rtl/serial_tx.sv | 110 +++++++++++
 2 files changed

// File: rtl/serial_tx_if.sv
// serial_tx_if: request/status bundle for the serial transmitter.
//   start : frame request (master -> slave)
//   din   : payload, DATA_W bits (master -> slave)
//   tx    : serial line, idle-high (slave -> master)
//   busy  : frame in progress (slave -> master)
//   done  : one-cycle completion pulse (slave -> master)
interface serial_tx_if #(
    parameter int DATA_W = 8
);
    logic              start;
    logic [DATA_W-1:0] din;
    logic              tx;
    logic              busy;
    logic              done;

    modport master (output start, din, input tx, busy, done);
    modport slave  (input start, din, output tx, busy, done);
endinterface

// File: rtl/serial_tx.sv
// serial_tx: start/data/stop serial transmitter, LSB first.
//   clk : clock, all state changes on the rising edge
//   rst : synchronous active-low reset
//   bus : serial_tx_if.slave (start, din in; tx, busy, done out)
// A frame is one low start bit, DATA_W data bits and one high stop bit,
// each held CLKS_PER_BIT cycles. done pulses in the first idle cycle after
// the stop bit; a start seen in that cycle begins the next frame at once.
module serial_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    serial_tx_if.slave  bus
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              bit_end;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        bit_end = (cnt_q == CNT_MAX);
        // Bit-period counter runs only inside a frame and wraps per bit.
        if (state_q == IDLE) cnt_d = '0;
        else                 cnt_d = bit_end ? '0 : cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (bus.start) begin
                    state_d = START;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    shreg_d = bus.din;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    idx_d   = '0;
                    tx_d    = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == IDX_MAX) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        tx_d    = shreg_q[0];
                        shreg_d = shreg_q >> 1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.tx   = tx_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule
